// File: rtl/shift_pkg.sv
// Shared types for the sequential shift/rotate unit.
// Mode encoding matches the ALU MODE field.
package shift_pkg;
  typedef enum logic [1:0] {LSL = 2'b00, LSR = 2'b01, ASR = 2'b10, ROL = 2'b11} shift_mode_t;
  typedef enum logic [1:0] {IDLE = 2'b00, SHIFT = 2'b01, FINISH = 2'b10} shift_state_t;
endpackage

// File: rtl/shift_step.sv
// Combinational single step: shifts/rotates w by k positions (k <= N).
// cout is the last bit to leave the word; lost is the OR of the bits dropped.
module shift_step
  import shift_pkg::*;
#(
  parameter int N  = 8,
  parameter int KW = 4
) (
  input  logic [N-1:0]  w,
  input  logic [KW-1:0] k,
  input  shift_mode_t   mode,
  input  logic          sign,
  output logic [N-1:0]  nxt,
  output logic          cout,
  output logic          lost
);
  logic [2*N-1:0] lsl_t, rsh_t, rol_t, fill;

  always_comb begin
    lsl_t = {{N{1'b0}}, w} << k;
    rol_t = {w, w} << k;
    // ASR fill: the top k bits take the sign latched at start
    fill  = (mode == ASR && sign) ? ~({(2*N){1'b1}} >> k) : '0;
    rsh_t = ({w, {N{1'b0}}} >> k) | fill;
    nxt   = w;
    cout  = 1'b0;
    lost  = 1'b0;
    case (mode)
      LSL: begin
        nxt  = lsl_t[N-1:0];
        cout = lsl_t[N];
        lost = |lsl_t[2*N-1:N];
      end
      LSR, ASR: begin
        nxt  = rsh_t[2*N-1:N];
        cout = rsh_t[N-1];
        lost = |rsh_t[N-1:0];
      end
      ROL: begin
        nxt  = rol_t[2*N-1:N];
        cout = rol_t[N];
        lost = |rol_t[N-1:0];
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/seq_shifter.sv
// Multi-cycle shift/rotate unit with START/BUSY/DONE handshake.
// Moves up to STEP positions per cycle; OUT is loaded on entry to FINISH.
module seq_shifter
  import shift_pkg::*;
#(
  parameter int N    = 8,
  parameter int STEP = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [1:0]   mode,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] out,
  output logic         overflow,
  output logic         carry
);
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] STEP_C = CW'(STEP);
  localparam logic [CW-1:0] N_C    = CW'(N);
  localparam logic [N-1:0]  N_B    = N'(N);

  shift_state_t state, state_nxt;
  shift_mode_t  mode_in, md;
  logic [N-1:0]  wrk, step_w;
  logic [CW-1:0] rem, k, amt;
  logic          sgn, step_c, step_l;

  assign mode_in = shift_mode_t'(mode);

  // Logical/arithmetic amounts saturate at N; rotates wrap
  always_comb begin
    amt = '0;
    if (mode_in == ROL) amt = CW'(b % N_B);
    else                amt = (b >= N_B) ? N_C : CW'(b);
  end

  assign k = (rem < STEP_C) ? rem : STEP_C;

  shift_step #(.N(N), .KW(CW)) u_step (
    .w    (wrk),
    .k    (k),
    .mode (md),
    .sign (sgn),
    .nxt  (step_w),
    .cout (step_c),
    .lost (step_l)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE:    if (start) state_nxt = (amt != '0) ? SHIFT : FINISH;
      SHIFT: begin
        busy = 1'b1;
        if (rem == k) state_nxt = FINISH;
      end
      FINISH: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrk      <= '0;
      rem      <= '0;
      md       <= LSL;
      sgn      <= 1'b0;
      out      <= '0;
      overflow <= 1'b0;
      carry    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          wrk      <= a;
          md       <= mode_in;
          sgn      <= a[N-1];
          rem      <= amt;
          overflow <= 1'b0;
          carry    <= 1'b0;
          if (amt == '0) out <= a;
        end
        SHIFT: begin
          wrk   <= step_w;
          rem   <= rem - k;
          carry <= step_c;
          if (md == LSL) overflow <= overflow | step_l;
          if (rem == k)  out      <= step_w;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_shifter.sv
// Bench for seq_shifter: STEP=1 and STEP=3 instances share stimulus and are
// checked against an arithmetic reference model.
module tb_seq_shifter;
  localparam int N = 8;
  localparam logic [1:0] M_LSL = 2'b00, M_LSR = 2'b01, M_ASR = 2'b10, M_ROL = 2'b11;

  logic clk = 1'b0, rst_n = 1'b1, start = 1'b0;
  logic [1:0] mode = '0;
  logic [N-1:0] a = '0, b = '0;
  logic busy1, done1, ovf1, cry1, busy3, done3, ovf3, cry3;
  logic [N-1:0] out1, out3;

  int total = 0, bad = 0;
  int lat1, lat3, busy_cnt1;

  always #5 clk = ~clk;

  seq_shifter #(.N(N), .STEP(1)) u_s1 (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .a(a), .b(b),
    .busy(busy1), .done(done1), .out(out1), .overflow(ovf1), .carry(cry1));

  seq_shifter #(.N(N), .STEP(3)) u_s3 (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .a(a), .b(b),
    .busy(busy3), .done(done3), .out(out3), .overflow(ovf3), .carry(cry3));

  function automatic void model(input logic [1:0] m, input logic [N-1:0] av, bv,
                                output logic [N-1:0] o, output logic ov, cy, output int amt);
    ov = 1'b0; cy = 1'b0;
    if (m == M_ROL) amt = int'(bv) % N;
    else            amt = (int'(bv) > N) ? N : int'(bv);
    case (m)
      M_LSL: begin
        o = av << amt;
        if (amt > 0) begin ov = ((av >> (N - amt)) != 0); cy = av[N-amt]; end
      end
      M_LSR: begin o = av >> amt; if (amt > 0) cy = av[amt-1]; end
      M_ASR: begin o = $signed(av) >>> amt; if (amt > 0) cy = av[amt-1]; end
      default: begin
        o = (amt == 0) ? av : ((av << amt) | (av >> (N - amt)));
        if (amt > 0) cy = o[0];
      end
    endcase
  endfunction

  // Drives one request and records DONE latency of both units (-1 on timeout).
  task automatic issue(input logic [1:0] m, input logic [N-1:0] av, bv);
    @(posedge clk);
    @(negedge clk);
    mode = m; a = av; b = bv; start = 1'b1;
    lat1 = -1; lat3 = -1; busy_cnt1 = 0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (busy1) busy_cnt1++;
      if (done1 && lat1 < 0) lat1 = c;
      if (done3 && lat3 < 0) lat3 = c;
      if (lat1 >= 0 && lat3 >= 0) break;
    end
  endtask

  task automatic test_reset;
    #1 rst_n = 1'b0;
    #2;
    total++;
    if ({busy1, done1, out1, ovf1, cry1} !== '0) begin
      bad++; $display("FAIL reset_s1 got busy=%b done=%b out=%h ovf=%b cy=%b want all 0", busy1, done1, out1, ovf1, cry1);
    end
    total++;
    if ({busy3, done3, out3, ovf3, cry3} !== '0) begin
      bad++; $display("FAIL reset_s3 got busy=%b done=%b out=%h ovf=%b cy=%b want all 0", busy3, done3, out3, ovf3, cry3);
    end
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_directed;
    logic [1:0] tm[8] = '{M_LSL, M_LSL, M_ROL, M_ROL, M_ASR, M_LSR, M_LSL, M_LSL};
    logic [N-1:0] ta[8] = '{8'h0B, 8'h2B, 8'h45, 8'h45, 8'h8B, 8'h8B, 8'h01, 8'h5A};
    logic [N-1:0] tbv[8] = '{8'd1, 8'd3, 8'd5, 8'd13, 8'h25, 8'h25, 8'd7, 8'd0};
    logic [N-1:0] eo; logic eov, ecy; int amt;
    for (int i = 0; i < 8; i++) begin
      issue(tm[i], ta[i], tbv[i]);
      model(tm[i], ta[i], tbv[i], eo, eov, ecy, amt);
      total++; if (out1 !== eo)  begin bad++; $display("FAIL dir%0d out_s1 got %h want %h", i, out1, eo); end
      total++; if (ovf1 !== eov) begin bad++; $display("FAIL dir%0d ovf_s1 got %b want %b", i, ovf1, eov); end
      total++; if (cry1 !== ecy) begin bad++; $display("FAIL dir%0d carry_s1 got %b want %b", i, cry1, ecy); end
      total++; if (lat1 != amt + 1) begin bad++; $display("FAIL dir%0d lat_s1 got %0d want %0d", i, lat1, amt + 1); end
      total++; if (busy_cnt1 != amt) begin bad++; $display("FAIL dir%0d busy_s1 got %0d want %0d", i, busy_cnt1, amt); end
      total++; if (out3 !== eo)  begin bad++; $display("FAIL dir%0d out_s3 got %h want %h", i, out3, eo); end
      total++; if (ovf3 !== eov) begin bad++; $display("FAIL dir%0d ovf_s3 got %b want %b", i, ovf3, eov); end
      total++; if (cry3 !== ecy) begin bad++; $display("FAIL dir%0d carry_s3 got %b want %b", i, cry3, ecy); end
      total++; if (lat3 != (amt + 2) / 3 + 1) begin bad++; $display("FAIL dir%0d lat_s3 got %0d want %0d", i, lat3, (amt + 2) / 3 + 1); end
    end
  endtask

  task automatic test_random;
    logic [1:0] m; logic [N-1:0] av, bv, eo; logic eov, ecy; int amt;
    for (int i = 0; i < 40; i++) begin
      m  = 2'($urandom_range(0, 3));
      av = 8'($urandom);
      bv = (i % 2 == 0) ? 8'($urandom_range(0, 10)) : 8'($urandom);
      issue(m, av, bv);
      model(m, av, bv, eo, eov, ecy, amt);
      total++; if ({out1, ovf1, cry1} !== {eo, eov, ecy}) begin
        bad++; $display("FAIL rnd%0d s1 m=%0d a=%h b=%h got %h/%b/%b want %h/%b/%b", i, m, av, bv, out1, ovf1, cry1, eo, eov, ecy);
      end
      total++; if ({out3, ovf3, cry3} !== {eo, eov, ecy}) begin
        bad++; $display("FAIL rnd%0d s3 m=%0d a=%h b=%h got %h/%b/%b want %h/%b/%b", i, m, av, bv, out3, ovf3, cry3, eo, eov, ecy);
      end
      total++; if (lat1 != amt + 1 || lat3 != (amt + 2) / 3 + 1) begin
        bad++; $display("FAIL rnd%0d latency got %0d/%0d want %0d/%0d", i, lat1, lat3, amt + 1, (amt + 2) / 3 + 1);
      end
    end
  endtask

  task automatic test_ignore_start;
    int n1 = 0, n3 = 0;
    repeat (2) @(posedge clk);
    @(negedge clk) begin mode = M_LSL; a = 8'h01; b = 8'd5; start = 1'b1; end
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk) begin mode = M_LSR; a = 8'hFF; b = 8'd1; start = 1'b1; end
    @(posedge clk); #1 start = 1'b0;
    for (int c = 0; c < 14; c++) begin
      @(posedge clk); #1;
      if (done1) n1++;
      if (done3) n3++;
    end
    total++; if (n1 != 1 || n3 != 1) begin bad++; $display("FAIL ignore_done_count got %0d/%0d want 1/1", n1, n3); end
    total++; if (out1 !== 8'h20) begin bad++; $display("FAIL ignore_out_s1 got %h want 20", out1); end
    total++; if (out3 !== 8'h20) begin bad++; $display("FAIL ignore_out_s3 got %h want 20", out3); end
  endtask

  task automatic test_reset_mid;
    int n = 0;
    @(negedge clk) begin mode = M_LSL; a = 8'h0F; b = 8'd6; start = 1'b1; end
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #3 rst_n = 1'b0;
    #1;
    total++;
    if ({busy1, done1, out1, ovf1, cry1, busy3, done3, out3, ovf3, cry3} !== '0) begin
      bad++; $display("FAIL reset_mid got s1 %b%b %h %b%b s3 %b%b %h %b%b want all 0",
                      busy1, done1, out1, ovf1, cry1, busy3, done3, out3, ovf3, cry3);
    end
    @(negedge clk) rst_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (done1 || done3 || busy1 || busy3) n++;
    end
    total++; if (n != 0) begin bad++; $display("FAIL reset_mid_no_done got %0d active cycles want 0", n); end
  endtask

  task automatic test_back_to_back;
    int n1 = 0, n3 = 0, e1, e3;
    logic [N-1:0] eo; logic eov, ecy; int amt;
    @(negedge clk) begin mode = M_LSL; a = 8'hC3; b = 8'd2; start = 1'b1; end
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (done1) n1++;
      if (done3) n3++;
    end
    start = 1'b0;
    model(M_LSL, 8'hC3, 8'd2, eo, eov, ecy, amt);
    // Each operation occupies latency+1 cycles before the next accept
    e1 = (20 - (amt + 1)) / (amt + 2) + 1;
    e3 = (20 - ((amt + 2) / 3 + 1)) / ((amt + 2) / 3 + 2) + 1;
    total++; if (n1 != e1) begin bad++; $display("FAIL b2b_count_s1 got %0d want %0d", n1, e1); end
    total++; if (n3 != e3) begin bad++; $display("FAIL b2b_count_s3 got %0d want %0d", n3, e3); end
    repeat (12) @(posedge clk);
    #1;
    total++; if ({out1, ovf1, cry1} !== {eo, eov, ecy}) begin
      bad++; $display("FAIL b2b_result got %h/%b/%b want %h/%b/%b", out1, ovf1, cry1, eo, eov, ecy);
    end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_random;
    test_ignore_start;
    test_reset_mid;
    test_back_to_back;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
